key_event_decoder: RTL and testbench
====================================

Name: key_event_decoder

Overview:
Input-side front end for the board's pushbuttons. It takes the raw active-low key lines and delivers clean key events to the display and control logic that drives the hex and LED outputs. The block synchronises and debounces each key, then generates press, release and auto-repeat events. Events reach the consumer two ways: per-key one-cycle pulses, and a serialised valid/ready event stream so the consumer never loses an event.

Parameters:
NUM_KEYS, 4, number of pushbutton channels (key code width fixed at 2 bits; NUM_KEYS ≤ 4)
DEBOUNCE_CYCLES, 240000, cycles the input must be stable before a level change is accepted (10 ms at 24 MHz)
REPEAT_DELAY_CYCLES, 12000000, cycles from the accepted press to the first repeat event (500 ms)
REPEAT_PERIOD_CYCLES, 2400000, cycles between subsequent repeat events (100 ms)

Ports:
clock  in  1  system clock (24 MHz)
reset_n  in  1  asynchronous active-low reset
key  in  NUM_KEYS  raw pushbuttons, active-low (0 = pressed)
repeat_en  in  1  1 = auto-repeat enabled for all keys
key_level  out  NUM_KEYS  debounced state, active-high (1 = held)
key_press  out  NUM_KEYS  one-cycle pulse on accepted press
key_release  out  NUM_KEYS  one-cycle pulse on accepted release
key_repeat  out  NUM_KEYS  one-cycle pulse per repeat tick
evt_valid  out  1  event stream valid
evt_ready  in  1  consumer accepts the event
evt_code  out  2  key index of the presented event
evt_kind  out  2  1 = press, 2 = repeat, 3 = release
evt_overflow  out  1  sticky flag: an event was dropped

Behaviour:
- Reset (async, reset_n = 0):
  - Sync flops set to 1 (released).
  - All FSMs go to IDLE and all counters clear.
  - All outputs are 0, including evt_overflow.
- Synchroniser: 2-FF per key, then inverted to active-high "raw_p". Latency from the key pin to the FSM is 2 cycles.
- Per-channel FSM (one debounce counter, one repeat counter):
  - IDLE: key_level = 0. raw_p = 1 → go to PCONF, counter = 0.
  - PCONF: raw_p = 0 → back to IDLE. Counter reaches DEBOUNCE_CYCLES-1 with raw_p still 1 → go to HELD, key_level = 1, pulse key_press, repeat counter = 0.
  - HELD:
    - raw_p = 0 → go to RCONF, counter = 0.
    - Otherwise, if repeat_en = 1, the repeat counter increments. It pulses key_repeat when it reaches REPEAT_DELAY_CYCLES-1 and then reloads so the next pulse comes REPEAT_PERIOD_CYCLES later.
    - repeat_en = 0 clears the repeat counter.
  - RCONF: key_level stays 1. raw_p = 1 → back to HELD (repeat timing continues). Counter reaches DEBOUNCE_CYCLES-1 with raw_p still 0 → go to IDLE, key_level = 0, pulse key_release.
  - Any bounce during a confirm state restarts that state's counter; no pulses are emitted.
- Pulse timing: press and release pulses occur 2 + DEBOUNCE_CYCLES cycles after a clean pin edge. All pulses are registered outputs, exactly 1 cycle wide.
- Event stream:
  - Each channel has 3 pending bits (press, repeat, release), set by the matching pulse.
  - Arbiter selection: lowest key index first; within a key, press, then release, then repeat.
  - The selected event is registered onto evt_code and evt_kind.
  - While evt_valid = 1 and evt_ready = 0, evt_code and evt_kind stay stable.
  - Transfer happens when evt_valid & evt_ready. That pending bit clears, and the next event, if any, is presented on the following cycle. The stream delivers at most one event per 2 cycles.
  - A pulse arriving for a bit that is already pending is dropped and sets evt_overflow. The flag clears only on reset.
  - A pulse and the clear of the same bit in the same cycle leave the bit set (the new event is kept, no overflow).
- Simultaneous presses on several keys produce independent pulses in the same cycle. The stream serialises them in index order.
- Unused channels (index ≥ NUM_KEYS) produce no events.

Decomposition:
- Shared package key_pkg:
  - evt_kind encodings EVT_PRESS = 1, EVT_REPEAT = 2, EVT_RELEASE = 3.
  - FSM state enum IDLE/PCONF/HELD/RCONF.
  - Default timing constants at 24 MHz.
- Sub-module key_debounce_channel: sync, FSM and repeat counter for one key, instantiated NUM_KEYS times. The pending bits and arbiter stay in the top level.

Test Plan:
Run with DEBOUNCE_CYCLES = 8, REPEAT_DELAY_CYCLES = 40, REPEAT_PERIOD_CYCLES = 10.
- Reset mid-operation: key[0] held 0 through HELD, then reset_n = 0 for 3 cycles → all outputs 0 immediately; after release of reset with key still 0, key_press[0] occurs again 10 cycles later.
- Clean press of key[2] for 100 cycles, repeat_en = 0 → key_press[2] 10 cycles after the edge; release pulse 10 cycles after the rising edge; no repeat pulses; stream emits code 2 kind 1, then code 2 kind 3.
- Bounce: key[1] toggles every 3 cycles for 30 cycles, then holds 0 → exactly one key_press[1], 10 cycles after the final edge; no release pulse.
- Auto-repeat: key[0] held 100 cycles with repeat_en = 1 → repeat pulses at 40, 50, 60, 70, 80, 90 cycles after key_press[0].
- Simultaneous/backpressure: key[3] and key[1] pressed in the same cycle with evt_ready = 0 → evt_valid = 1 with code 1 held stable; raising evt_ready then delivers code 1, then code 3, each kind 1.
- Overflow: evt_ready = 0 while key[0] does press, release, press → second press dropped, evt_overflow = 1 and stays 1.

Source files
------------

// File: rtl/key_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// key_pkg -- shared encodings and default timing for key events
// Rev 1.0
// ============================================================
package key_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PCONF = 2'd1,
    HELD  = 2'd2,
    RCONF = 2'd3
  } key_state_e;

  // 24 MHz system clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat rate
  localparam int DEF_DEBOUNCE_CYCLES      = 240000;
  localparam int DEF_REPEAT_DELAY_CYCLES  = 12000000;
  localparam int DEF_REPEAT_PERIOD_CYCLES = 2400000;

endpackage
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// key_debounce_channel -- sync, debounce FSM and auto-repeat for one key
// Rev 1.0
// ============================================================
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE    = DW'(1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE    = RW'(1);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY_CYCLES - REPEAT_PERIOD_CYCLES);

  logic [1:0]    sync;
  logic          raw_p;
  key_state_e    state, state_next;
  logic [DW-1:0] deb_cnt, deb_cnt_next;
  logic [RW-1:0] rep_cnt, rep_cnt_next;
  logic          press_next, release_next, repeat_next;

  assign raw_p = ~sync[1];
  assign level = (state == HELD) || (state == RCONF);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= 2'b11;
      state         <= IDLE;
      deb_cnt       <= '0;
      rep_cnt       <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync          <= {sync[0], key_n};
      state         <= state_next;
      deb_cnt       <= deb_cnt_next;
      rep_cnt       <= rep_cnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      repeat_pulse  <= repeat_next;
    end
  end

  always_comb begin
    state_next   = state;
    deb_cnt_next = deb_cnt;
    rep_cnt_next = rep_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;
    case (state)
      IDLE: begin
        if (raw_p) begin
          state_next   = PCONF;
          deb_cnt_next = '0;
        end
      end
      PCONF: begin
        if (!raw_p) begin
          state_next = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = HELD;
          press_next   = 1'b1;
          rep_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt + DEB_ONE;
        end
      end
      HELD: begin
        if (!raw_p) begin
          state_next   = RCONF;
          deb_cnt_next = '0;
        end else if (!repeat_en) begin
          rep_cnt_next = '0;
        end else if (rep_cnt == REP_LAST) begin
          // reload so later ticks are spaced by the repeat period
          repeat_next  = 1'b1;
          rep_cnt_next = REP_RELOAD;
        end else begin
          rep_cnt_next = rep_cnt + REP_ONE;
        end
      end
      RCONF: begin
        if (raw_p) begin
          state_next = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else begin
          deb_cnt_next = deb_cnt + DEB_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/key_event_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// key_event_decoder -- debounced key pulses plus serialised event stream
// Rev 1.0
// ============================================================
module key_event_decoder
  import key_pkg::*;
#(
  parameter int NUM_KEYS             = 4,
  parameter int DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key,
  input  logic                repeat_en,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [1:0]          evt_code,
  output logic [1:0]          evt_kind,
  output logic                evt_overflow
);

  localparam int NCH = 4;

  logic [NCH-1:0] press_w, release_w, repeat_w;
  logic [NCH-1:0] pend_press, pend_release, pend_repeat;
  logic [NCH-1:0] clr_press, clr_release, clr_repeat;
  logic           xfer, overflow_hit, sel_any;
  logic [1:0]     sel_code, sel_kind;

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_chan
      if (k < NUM_KEYS) begin : g_used
        key_debounce_channel #(
          .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
          .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
          .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
        ) u_chan (
          .clock        (clock),
          .reset_n      (reset_n),
          .key_n        (key[k]),
          .repeat_en    (repeat_en),
          .level        (key_level[k]),
          .press_pulse  (press_w[k]),
          .release_pulse(release_w[k]),
          .repeat_pulse (repeat_w[k])
        );
      end else begin : g_unused
        assign press_w[k]   = 1'b0;
        assign release_w[k] = 1'b0;
        assign repeat_w[k]  = 1'b0;
      end
    end
  endgenerate

  assign key_press   = press_w[NUM_KEYS-1:0];
  assign key_release = release_w[NUM_KEYS-1:0];
  assign key_repeat  = repeat_w[NUM_KEYS-1:0];

  assign xfer = evt_valid & evt_ready;

  always_comb begin
    clr_press   = '0;
    clr_release = '0;
    clr_repeat  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (xfer && (evt_code == 2'(k))) begin
        clr_press[k]   = (evt_kind == EVT_PRESS);
        clr_release[k] = (evt_kind == EVT_RELEASE);
        clr_repeat[k]  = (evt_kind == EVT_REPEAT);
      end
    end
  end

  // a pulse coinciding with the clear of its own bit is kept, not dropped
  assign overflow_hit = |(press_w   & pend_press   & ~clr_press)
                      | |(release_w & pend_release & ~clr_release)
                      | |(repeat_w  & pend_repeat  & ~clr_repeat);

  always_comb begin
    sel_any  = 1'b0;
    sel_code = '0;
    sel_kind = EVT_PRESS;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_press[k] || pend_release[k] || pend_repeat[k]) begin
        sel_any  = 1'b1;
        sel_code = 2'(k);
        if (pend_press[k])        sel_kind = EVT_PRESS;
        else if (pend_release[k]) sel_kind = EVT_RELEASE;
        else                      sel_kind = EVT_REPEAT;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_press   <= '0;
      pend_release <= '0;
      pend_repeat  <= '0;
      evt_valid    <= 1'b0;
      evt_code     <= '0;
      evt_kind     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend_press   <= (pend_press   & ~clr_press)   | press_w;
      pend_release <= (pend_release & ~clr_release) | release_w;
      pend_repeat  <= (pend_repeat  & ~clr_repeat)  | repeat_w;
      if (overflow_hit) evt_overflow <= 1'b1;
      if (xfer) begin
        evt_valid <= 1'b0;
      end else if (!evt_valid && sel_any) begin
        evt_valid <= 1'b1;
        evt_code  <= sel_code;
        evt_kind  <= sel_kind;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for key_event_decoder with short debounce/repeat timing.
module tb_key_event_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] key;
  logic       repeat_en;
  logic [3:0] key_level, key_press, key_release, key_repeat;
  logic       evt_valid, evt_ready, evt_overflow;
  logic [1:0] evt_code, evt_kind;

  key_event_decoder #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY_CYCLES(40), .REPEAT_PERIOD_CYCLES(10)
  ) dut (
    .clock(clock), .reset_n(reset_n), .key(key), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_kind(evt_kind), .evt_overflow(evt_overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int k; int hold; bit ren;
    int exp_press; int exp_rel; int exp_nrep; int exp_rep1; int exp_nev;
  } vec_t;
  vec_t vecs[4];

  int n_tests = 0, n_fail = 0;
  int np[4], nr[4], nrep[4], nlev[4], tp[4], tr[4], trep1[4];
  logic [3:0] evq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      np[k] = 0; nr[k] = 0; nrep[k] = 0; nlev[k] = 0;
      tp[k] = -1; tr[k] = -1; trep1[k] = -1;
    end
    evq.delete();
  endtask

  // advance one clock; a transfer is logged from the handshake seen before the edge
  task automatic tick();
    logic       pv;
    logic [3:0] pe;
    pv = evt_valid && evt_ready;
    pe = {evt_code, evt_kind};
    @(posedge clock);
    #1;
    if (pv) evq.push_back(pe);
    for (int k = 0; k < 4; k++) begin
      if (key_press[k])   begin np[k]++; tp[k] = cyc; end
      if (key_release[k]) begin nr[k]++; tr[k] = cyc; end
      if (key_repeat[k])  begin if (nrep[k] == 0) trep1[k] = cyc; nrep[k]++; end
      if (key_level[k])   nlev[k]++;
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, key_level, key_press, key_release, key_repeat,
            evt_valid, evt_code, evt_kind, evt_overflow};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, cnt;
    logic all_k;

    // key driven at a negedge is captured on the next edge; pulses land 10 cycles later
    vecs[0] = '{2, 100, 1'b0, 11, 11, 0, 0, 2};
    vecs[1] = '{0, 100, 1'b1, 11, 11, 6, 40, 8};
    vecs[2] = '{3, 30, 1'b1, 11, 11, 0, 0, 2};
    vecs[3] = '{1, 55, 1'b1, 11, 11, 1, 40, 3};

    reset_n = 1'b0; key = 4'hF; repeat_en = 1'b0; evt_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", all_outs(), 32'd0);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 4; i++) begin
      clear_stats();
      @(negedge clock);
      key[vecs[i].k] = 1'b0;
      repeat_en = vecs[i].ren;
      t0 = cyc;
      repeat (vecs[i].hold) tick();
      @(negedge clock);
      key[vecs[i].k] = 1'b1;
      t1 = cyc;
      repeat (30) tick();
      check($sformatf("v%0d press_count", i), np[vecs[i].k], 1);
      check($sformatf("v%0d press_time", i), tp[vecs[i].k] - t0, vecs[i].exp_press);
      check($sformatf("v%0d release_count", i), nr[vecs[i].k], 1);
      check($sformatf("v%0d release_time", i), tr[vecs[i].k] - t1, vecs[i].exp_rel);
      check($sformatf("v%0d repeat_count", i), nrep[vecs[i].k], vecs[i].exp_nrep);
      if (vecs[i].exp_nrep > 0)
        check($sformatf("v%0d first_repeat", i), trep1[vecs[i].k] - tp[vecs[i].k], vecs[i].exp_rep1);
      check($sformatf("v%0d level_cycles", i), nlev[vecs[i].k], vecs[i].hold);
      check($sformatf("v%0d event_count", i), evq.size(), vecs[i].exp_nev);
      all_k = 1'b1;
      foreach (evq[j]) if (evq[j][3:2] != 2'(vecs[i].k)) all_k = 1'b0;
      check($sformatf("v%0d event_codes", i), all_k, 1);
      if (evq.size() > 0) begin
        check($sformatf("v%0d first_event", i), evq[0], {2'(vecs[i].k), 2'd1});
        check($sformatf("v%0d last_event", i), evq[evq.size()-1], {2'(vecs[i].k), 2'd3});
      end
    end

    // bounce on key 1: toggles every 3 cycles, then settles low
    clear_stats();
    repeat_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      key[1] = (i % 2 == 1);
      repeat (3) tick();
    end
    @(negedge clock);
    key[1] = 1'b0;
    t0 = cyc;
    repeat (20) tick();
    check("bounce press_count", np[1], 1);
    check("bounce press_time", tp[1] - t0, 11);
    check("bounce release_count", nr[1], 0);
    @(negedge clock);
    key[1] = 1'b1;
    repeat (25) tick();

    // simultaneous presses under backpressure
    clear_stats();
    @(negedge clock);
    evt_ready = 1'b0;
    key[3] = 1'b0; key[1] = 1'b0;
    t0 = cyc;
    repeat (13) tick();
    check("simul press1_time", tp[1] - t0, 11);
    check("simul press3_time", tp[3] - t0, 11);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (evt_valid && evt_code == 2'd1 && evt_kind == 2'd1) cnt++;
    end
    check("simul stall_stable", cnt, 10);
    @(negedge clock);
    evt_ready = 1'b1;
    evq.delete();
    repeat (6) tick();
    check("simul event_count", evq.size(), 2);
    if (evq.size() == 2) begin
      check("simul event0", evq[0], 4'b0101);
      check("simul event1", evq[1], 4'b1101);
    end
    @(negedge clock);
    key = 4'hF;
    repeat (25) tick();

    // overflow: press, release, press with the consumer stalled
    clear_stats();
    @(negedge clock);
    evt_ready = 1'b0;
    key[0] = 1'b0;
    repeat (20) tick();
    @(negedge clock);
    key[0] = 1'b1;
    repeat (20) tick();
    check("ovf before_second_press", evt_overflow, 0);
    @(negedge clock);
    key[0] = 1'b0;
    repeat (20) tick();
    check("ovf after_second_press", evt_overflow, 1);
    @(negedge clock);
    evt_ready = 1'b1;
    evq.delete();
    repeat (10) tick();
    check("ovf event_count", evq.size(), 2);
    if (evq.size() == 2) begin
      check("ovf event0", evq[0], 4'b0001);
      check("ovf event1", evq[1], 4'b0011);
    end
    check("ovf sticky", evt_overflow, 1);

    // reset while key 0 is held
    check("rst level_before", key_level[0], 1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst outputs_immediate", all_outs(), 32'd0);
    repeat (3) @(negedge clock);
    clear_stats();
    reset_n = 1'b1;
    t0 = cyc;
    repeat (15) tick();
    check("rst press_count", np[0], 1);
    check("rst press_time", tp[0] - t0, 11);

    @(negedge clock);
    key = 4'hF;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
